uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART transmitter between up to `N_REQ` byte producers, such as the time-stamp logic and status reporters. It sits between the requesters and the transmitter's enable and data inputs.
- Grants one requester at a time.
- Holds the transmitter enable across exactly one baud tick.
- Tracks the frame through the transmitter's busy flag.
- Reports a timeout if the transmitter never starts.

---
 rtl/uart_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_tx_sched.sv | 142 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and default constants for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    localparam int DEF_TIMEOUT_TICKS = 2;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic             valid
);

    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!valid && req[idx[PTR_W-1:0]]) begin
                valid                = 1'b1;
                win[idx[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N_REQ byte producers, round-robin,
// holding tx_en across exactly one baud tick and tracking the frame via tx_busy.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = 8,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic                      tx_en,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      sched_busy,
    output logic                      timeout,
    output logic [CNT_W-1:0]          frames_sent
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int TCNT_W = $clog2(TIMEOUT_TICKS + 1);

    sched_state_t        state_reg;
    logic [PTR_W-1:0]    ptr_reg;
    logic [PTR_W-1:0]    ptr_next;
    logic [TCNT_W-1:0]   tick_cnt_reg;
    logic [N_REQ-1:0]    grant_reg;
    logic                tx_en_reg;
    logic [DATA_W-1:0]   tx_data_reg;
    logic                sched_busy_reg;
    logic                timeout_reg;
    logic [CNT_W-1:0]    frames_sent_reg;

    logic [N_REQ-1:0]    win;
    logic                arb_valid;
    logic [DATA_W-1:0]   masked_data [N_REQ];
    logic [DATA_W-1:0]   win_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_reg),
        .win   (win),
        .valid (arb_valid)
    );

    // One-hot AND-OR mux of the winner's byte.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign masked_data[gi] = req_data[gi*DATA_W +: DATA_W] & {DATA_W{win[gi]}};
        end
    endgenerate

    always_comb begin
        win_data = '0;
        ptr_next = ptr_reg;
        for (int i = 0; i < N_REQ; i++) begin
            win_data = win_data | masked_data[i];
            if (win[i]) begin
                ptr_next = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            tick_cnt_reg    <= '0;
            grant_reg       <= '0;
            tx_en_reg       <= 1'b0;
            tx_data_reg     <= '0;
            sched_busy_reg  <= 1'b0;
            timeout_reg     <= 1'b0;
            frames_sent_reg <= '0;
        end else begin
            grant_reg   <= '0;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arb_valid) begin
                        grant_reg      <= win;
                        tx_data_reg    <= win_data;
                        ptr_reg        <= ptr_next;
                        tx_en_reg      <= 1'b1;
                        sched_busy_reg <= 1'b1;
                        state_reg      <= LOAD;
                    end
                end
                LOAD: begin
                    if (tick) begin
                        tx_en_reg    <= 1'b0;
                        tick_cnt_reg <= '0;
                        state_reg    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // A busy seen on the same edge as the final tick still counts as a start.
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (tick) begin
                        if (tick_cnt_reg == TCNT_W'(TIMEOUT_TICKS - 1)) begin
                            timeout_reg    <= 1'b1;
                            sched_busy_reg <= 1'b0;
                            state_reg      <= IDLE;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TCNT_W'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        frames_sent_reg <= frames_sent_reg + CNT_W'(1);
                        sched_busy_reg  <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
                default: begin
                    tx_en_reg      <= 1'b0;
                    sched_busy_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign tx_en       = tx_en_reg;
    assign tx_data     = tx_data_reg;
    assign sched_busy  = sched_busy_reg;
    assign timeout     = timeout_reg;
    assign frames_sent = frames_sent_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with hand-computed expectations.
module tb_uart_tx_sched;

    logic        clk;
    logic        reset;
    logic        tick;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        sched_busy;
    logic        timeout;
    logic [15:0] frames_sent;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_sched #(
        .N_REQ         (4),
        .DATA_W        (8),
        .TIMEOUT_TICKS (2),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .sched_busy  (sched_busy),
        .timeout     (timeout),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        tick    = 1'b0;
        tx_busy = 1'b0;
        req     = 4'b0000;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Waits (bounded) for a grant, then walks the frame through LOAD, WAIT_BUSY, WAIT_DONE.
    task automatic run_frame(input logic [3:0] exp_grant, input logic [7:0] exp_data,
                             input int busy_ticks, input logic drop_req);
        int guard;
        guard = 0;
        while (grant == 4'b0000 && guard < 8) begin
            step();
            guard++;
        end
        chk("grant", {28'd0, grant}, {28'd0, exp_grant});
        chk("tx_data", {24'd0, tx_data}, {24'd0, exp_data});
        chk("tx_en_rise", {31'd0, tx_en}, 32'd1);
        if (drop_req) req = 4'b0000;
        step();
        chk("grant_pulse", {28'd0, grant}, 32'd0);
        chk("tx_en_hold", {31'd0, tx_en}, 32'd1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("tx_en_fall", {31'd0, tx_en}, 32'd0);
        tx_busy = 1'b1;
        step();
        repeat (busy_ticks) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        tx_busy = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] fdat [4];
        fdat     = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        reset    = 1'b0;
        tick     = 1'b0;
        tx_busy  = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0000_0000;
        #1;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_tx_en", {31'd0, tx_en}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_sched_busy", {31'd0, sched_busy}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_frames", {16'd0, frames_sent}, 32'd0);

        // Reset asserted in the middle of LOAD
        do_reset();
        req_data = 32'h0077_0000;
        req      = 4'b0100;
        step();
        chk("load_tx_en", {31'd0, tx_en}, 32'd1);
        chk("load_grant", {28'd0, grant}, 32'h4);
        req = 4'b0000;
        #2;
        reset = 1'b0;
        #1;
        chk("async_tx_en", {31'd0, tx_en}, 32'd0);
        chk("async_tx_data", {24'd0, tx_data}, 32'd0);
        chk("async_sched_busy", {31'd0, sched_busy}, 32'd0);
        reset = 1'b1;
        step();
        req = 4'b1001;
        step();
        chk("post_rst_grant", {28'd0, grant}, 32'h1);

        // Single frame from requester 2
        do_reset();
        req_data = 32'h00A5_0000;
        req      = 4'b0100;
        run_frame(4'b0100, 8'hA5, 10, 1'b1);
        chk("single_frames", {16'd0, frames_sent}, 32'd1);
        chk("single_idle", {31'd0, sched_busy}, 32'd0);

        // Fairness with all four requesting
        do_reset();
        req_data = {fdat[3], fdat[2], fdat[1], fdat[0]};
        req      = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            run_frame(4'(1 << (k % 4)), fdat[k % 4], 1, 1'b0);
        end
        chk("fair_frames", {16'd0, frames_sent}, 32'd8);
        req = 4'b0000;

        // Timeout: transmitter never starts
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b0010;
        step();
        chk("to_grant", {28'd0, grant}, 32'h2);
        req  = 4'b0000;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("to_tx_en_fall", {31'd0, tx_en}, 32'd0);
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("to_tick1", {31'd0, timeout}, 32'd0);
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("to_tick2", {31'd0, timeout}, 32'd1);
        chk("to_idle", {31'd0, sched_busy}, 32'd0);
        req = 4'b0101;
        step();
        chk("to_pulse_end", {31'd0, timeout}, 32'd0);
        chk("to_frames", {16'd0, frames_sent}, 32'd0);
        chk("to_next_grant", {28'd0, grant}, 32'h4);
        req = 4'b0000;

        // Coincident tick and tx_busy on the would-be timeout tick
        do_reset();
        req = 4'b0001;
        step();
        req  = 4'b0000;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        tick    = 1'b1;
        tx_busy = 1'b1;
        step();
        tick = 1'b0;
        chk("coin_timeout", {31'd0, timeout}, 32'd0);
        chk("coin_busy", {31'd0, sched_busy}, 32'd1);
        step();
        step();
        tx_busy = 1'b0;
        step();
        chk("coin_frames", {16'd0, frames_sent}, 32'd1);

        // Frame counter wrap
        do_reset();
        force dut.frames_sent_reg = 16'hFFFF;
        step();
        release dut.frames_sent_reg;
        chk("wrap_preload", {16'd0, frames_sent}, 32'hFFFF);
        req_data = 32'h0000_005A;
        req      = 4'b0001;
        run_frame(4'b0001, 8'h5A, 2, 1'b1);
        chk("wrap_frames", {16'd0, frames_sent}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
